// File: rtl/blood_ph_pkg.sv
// ============================================================================
// Module : blood_ph_pkg
// Brief  : Shared types and event codes for the blood-pH monitor.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package blood_ph_pkg;

  typedef enum logic [2:0] {
    ST_NORMAL     = 3'd0,
    ST_PEND_LOW   = 3'd1,
    ST_PEND_HIGH  = 3'd2,
    ST_ALARM_LOW  = 3'd3,
    ST_ALARM_HIGH = 3'd4
  } ch_state_e;

  typedef enum logic [1:0] {
    CL_NORM = 2'd0,
    CL_LOW  = 2'd1,
    CL_HIGH = 2'd2
  } ph_class_e;

  localparam logic [1:0] EV_LOW  = 2'b01;
  localparam logic [1:0] EV_HIGH = 2'b10;

  function automatic logic [1:0] class_to_code(input ph_class_e c);
    return (c == CL_HIGH) ? EV_HIGH : EV_LOW;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ph_channel_fsm.sv
// ============================================================================
// Module : ph_channel_fsm
// Brief  : Per-channel persistence FSM; raises a latched alarm after PERSIST
//          consecutive abnormal samples, cleared by ack once readings are normal.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ph_channel_fsm
  import blood_ph_pkg::*;
#(
  parameter int PERSIST = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_i,
  input  ph_class_e  class_i,
  input  logic       ack_i,
  output logic       alarm_low_o,
  output logic       alarm_high_o,
  output logic       raise_o,
  output logic [1:0] raise_code_o
);

  localparam int CNT_W = $clog2(PERSIST + 1);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ph_class_e        last_q, last_d;
  logic             w_pend_same;
  logic [CNT_W-1:0] w_cnt_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_NORMAL;
      cnt_q   <= '0;
      last_q  <= CL_NORM;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    raise_o      = 1'b0;
    raise_code_o = 2'b00;
    w_pend_same  = 1'b0;
    w_cnt_n      = '0;
    if (sample_i) last_d = class_i;
    case (state_q)
      ST_NORMAL, ST_PEND_LOW, ST_PEND_HIGH: begin
        if (sample_i) begin
          if (class_i == CL_NORM) begin
            state_d = ST_NORMAL;
            cnt_d   = '0;
          end else begin
            // A run continues only when the abnormal direction matches the pending one.
            w_pend_same = ((class_i == CL_LOW)  && (state_q == ST_PEND_LOW)) ||
                          ((class_i == CL_HIGH) && (state_q == ST_PEND_HIGH));
            w_cnt_n     = w_pend_same ? (cnt_q + CNT_W'(1)) : CNT_W'(1);
            cnt_d       = w_cnt_n;
            if (w_cnt_n >= CNT_W'(PERSIST)) begin
              state_d      = (class_i == CL_LOW) ? ST_ALARM_LOW : ST_ALARM_HIGH;
              raise_o      = 1'b1;
              raise_code_o = class_to_code(class_i);
            end else begin
              state_d = (class_i == CL_LOW) ? ST_PEND_LOW : ST_PEND_HIGH;
            end
          end
        end
      end
      ST_ALARM_LOW, ST_ALARM_HIGH: begin
        if (ack_i && (last_d == CL_NORM)) begin
          state_d = ST_NORMAL;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_NORMAL;
        cnt_d   = '0;
      end
    endcase
  end

  assign alarm_low_o  = (state_q == ST_ALARM_LOW);
  assign alarm_high_o = (state_q == ST_ALARM_HIGH);

endmodule

`default_nettype wire

// File: rtl/blood_ph_monitor.sv
// ============================================================================
// Module : blood_ph_monitor
// Brief  : Multi-channel blood-pH classifier with persistence alarms and events.
//          Optional per-channel min/max statistics under BLOOD_PH_STATS_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module blood_ph_monitor
  import blood_ph_pkg::*;
#(
  parameter  int PH_W    = 4,
  parameter  int NUM_CH  = 4,
  parameter  int LOW_TH  = 7,
  parameter  int HIGH_TH = 8,
  parameter  int PERSIST = 3,
  localparam int CW      = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW-1:0]     in_ch,
  input  logic [PH_W-1:0]   in_ph,
  input  logic              ack,
  input  logic [CW-1:0]     ack_ch,
  output logic [NUM_CH-1:0] alarm_low,
  output logic [NUM_CH-1:0] alarm_high,
  output logic              event_valid,
  output logic [CW-1:0]     event_ch,
  output logic [1:0]        event_code,
  input  logic [CW-1:0]     stat_ch,
  output logic [PH_W-1:0]   stat_min,
  output logic [PH_W-1:0]   stat_max
);

  ph_class_e         w_class;
  logic              s1_valid_q;
  logic [CW-1:0]     s1_ch_q;
  ph_class_e         s1_class_q;
  logic [NUM_CH-1:0] w_sample;
  logic [NUM_CH-1:0] w_ack;
  logic [NUM_CH-1:0] w_raise;
  logic [1:0]        w_raise_code [NUM_CH];
  logic              ev_valid_d;
  logic [CW-1:0]     ev_ch_d;
  logic [1:0]        ev_code_d;

  assign in_ready = !rst;

  always_comb begin
    w_class = CL_NORM;
    if (in_ph < PH_W'(LOW_TH))       w_class = CL_LOW;
    else if (in_ph > PH_W'(HIGH_TH)) w_class = CL_HIGH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_ch_q    <= '0;
      s1_class_q <= CL_NORM;
    end else begin
      s1_valid_q <= in_valid;
      s1_ch_q    <= in_ch;
      s1_class_q <= w_class;
    end
  end

  // Decoding by equality means out-of-range channel numbers select nothing.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign w_sample[i] = s1_valid_q && (s1_ch_q == CW'(i));
    assign w_ack[i]    = ack && (ack_ch == CW'(i));

    ph_channel_fsm #(
      .PERSIST (PERSIST)
    ) u_fsm (
      .clk          (clk),
      .rst          (rst),
      .sample_i     (w_sample[i]),
      .class_i      (s1_class_q),
      .ack_i        (w_ack[i]),
      .alarm_low_o  (alarm_low[i]),
      .alarm_high_o (alarm_high[i]),
      .raise_o      (w_raise[i]),
      .raise_code_o (w_raise_code[i])
    );
  end

  always_comb begin
    ev_valid_d = 1'b0;
    ev_ch_d    = '0;
    ev_code_d  = 2'b00;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_raise[i]) begin
        ev_valid_d = 1'b1;
        ev_ch_d    = CW'(i);
        ev_code_d  = w_raise_code[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      event_valid <= 1'b0;
      event_ch    <= '0;
      event_code  <= 2'b00;
    end else begin
      event_valid <= ev_valid_d;
      event_ch    <= ev_ch_d;
      event_code  <= ev_code_d;
    end
  end

`ifdef BLOOD_PH_STATS_EN
  logic [PH_W-1:0] s1_ph_q;
  logic [PH_W-1:0] min_q [NUM_CH];
  logic [PH_W-1:0] max_q [NUM_CH];

  always_ff @(posedge clk) begin
    if (rst) s1_ph_q <= '0;
    else     s1_ph_q <= in_ph;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst) begin
        min_q[i] <= '1;
        max_q[i] <= '0;
      end else if (w_sample[i]) begin
        if (s1_ph_q < min_q[i]) min_q[i] <= s1_ph_q;
        if (s1_ph_q > max_q[i]) max_q[i] <= s1_ph_q;
      end
    end
  end

  always_comb begin
    stat_min = '0;
    stat_max = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (stat_ch == CW'(i)) begin
        stat_min = min_q[i];
        stat_max = max_q[i];
      end
    end
  end
`else
  logic unused_stat_ch;
  assign unused_stat_ch = ^stat_ch;
  assign stat_min = '0;
  assign stat_max = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_blood_ph_monitor.sv
// Bench for blood_ph_monitor: directed vectors, a run-length behavioural model
// checked every cycle, and literal expectations at key points.
`default_nettype none

module tb_blood_ph_monitor;

  localparam int PH_W    = 4;
  localparam int NUM_CH  = 4;
  localparam int LOW_TH  = 7;
  localparam int HIGH_TH = 8;
  localparam int PERSIST = 3;
  localparam int CW      = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [CW-1:0]     in_ch;
  logic [PH_W-1:0]   in_ph;
  logic              ack;
  logic [CW-1:0]     ack_ch;
  logic [NUM_CH-1:0] alarm_low;
  logic [NUM_CH-1:0] alarm_high;
  logic              event_valid;
  logic [CW-1:0]     event_ch;
  logic [1:0]        event_code;
  logic [CW-1:0]     stat_ch;
  logic [PH_W-1:0]   stat_min;
  logic [PH_W-1:0]   stat_max;

  blood_ph_monitor #(
    .PH_W(PH_W), .NUM_CH(NUM_CH), .LOW_TH(LOW_TH), .HIGH_TH(HIGH_TH), .PERSIST(PERSIST)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ch(in_ch), .in_ph(in_ph), .ack(ack), .ack_ch(ack_ch),
    .alarm_low(alarm_low), .alarm_high(alarm_high),
    .event_valid(event_valid), .event_ch(event_ch), .event_code(event_code),
    .stat_ch(stat_ch), .stat_min(stat_min), .stat_max(stat_max)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: class 0 normal, 1 low, 2 high; alarm 0 none else the alarmed class.
  int m_alarm   [NUM_CH];
  int pre_alarm [NUM_CH];
  int m_run_cls [NUM_CH];
  int m_run_len [NUM_CH];
  int m_last    [NUM_CH];
  int m_min     [NUM_CH];
  int m_max     [NUM_CH];
  bit p_valid;
  int p_ch, p_ph, c;
  bit e_valid, m_was_rst, started;
  int e_ch, e_code;

  function automatic int classify(input int ph);
    if (ph < LOW_TH)  return 1;
    if (ph > HIGH_TH) return 2;
    return 0;
  endfunction

  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_alarm[i] = 0; m_run_cls[i] = 0; m_run_len[i] = 0; m_last[i] = 0;
        m_min[i] = 15;  m_max[i] = 0;
      end
      p_valid = 1'b0; e_valid = 1'b0; e_ch = 0; e_code = 0; m_was_rst = 1'b1;
    end else begin
      m_was_rst = 1'b0;
      e_valid   = 1'b0;
      for (int i = 0; i < NUM_CH; i++) pre_alarm[i] = m_alarm[i];
      if (p_valid) begin
        c = classify(p_ph);
        m_last[p_ch] = c;
        if (p_ph < m_min[p_ch]) m_min[p_ch] = p_ph;
        if (p_ph > m_max[p_ch]) m_max[p_ch] = p_ph;
        if (m_alarm[p_ch] == 0) begin
          if (c == 0) m_run_len[p_ch] = 0;
          else if (c == m_run_cls[p_ch] && m_run_len[p_ch] > 0) m_run_len[p_ch]++;
          else begin m_run_cls[p_ch] = c; m_run_len[p_ch] = 1; end
          if (m_run_len[p_ch] >= PERSIST) begin
            m_alarm[p_ch] = c; m_run_len[p_ch] = 0;
            e_valid = 1'b1; e_ch = p_ch; e_code = c;
          end
        end
      end
      if (ack && pre_alarm[ack_ch] != 0 && m_last[ack_ch] == 0) m_alarm[ack_ch] = 0;
      p_valid = in_valid; p_ch = in_ch; p_ph = in_ph;
    end
  end

  logic [NUM_CH-1:0] x_lo, x_hi;
  int x_min, x_max;

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < NUM_CH; i++) begin
        x_lo[i] = (m_alarm[i] == 1);
        x_hi[i] = (m_alarm[i] == 2);
      end
`ifdef BLOOD_PH_STATS_EN
      x_min = m_min[stat_ch]; x_max = m_max[stat_ch];
`else
      x_min = 0; x_max = 0;
`endif
      chk("in_ready", in_ready, !rst);
      chk("alarm_low", alarm_low, x_lo);
      chk("alarm_high", alarm_high, x_hi);
      chk("event_valid", event_valid, e_valid);
      if (e_valid) begin
        chk("event_ch", event_ch, e_ch);
        chk("event_code", event_code, e_code);
      end
      if (m_was_rst) begin
        chk("rst_event_ch", event_ch, 0);
        chk("rst_event_code", event_code, 0);
      end
      chk("stat_min", stat_min, x_min);
      chk("stat_max", stat_max, x_max);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int ch, input int ph);
    in_valid = 1'b1; in_ch = CW'(ch); in_ph = PH_W'(ph);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_ch = '0; in_ph = '0;
    ack = 1'b0; ack_ch = '0; stat_ch = 2'd2;
    step(); step();
    chk("lit_ready_in_rst", in_ready, 0);
    chk("lit_rst_alarm_low", alarm_low, 0);
    chk("lit_rst_event", event_valid, 0);
    rst = 1'b0;
    step();
    chk("lit_ready", in_ready, 1);

    send(0, 7); send(0, 8); send(0, 7); step(); step();
    chk("lit_normal_low", alarm_low, 0);
    chk("lit_normal_high", alarm_high, 0);

    send(1, 5); send(1, 5); send(1, 5);
    chk("lit_ch1_no_event_yet", event_valid, 0);
    step();
    chk("lit_ch1_event", event_valid, 1);
    chk("lit_ch1_event_ch", event_ch, 1);
    chk("lit_ch1_event_code", event_code, 1);
    chk("lit_ch1_alarm", alarm_low, 4'b0010);
    step();
    chk("lit_ch1_pulse_once", event_valid, 0);

    send(2, 10); send(2, 10); send(2, 7); send(2, 10); send(2, 10); send(2, 10);
    step();
    chk("lit_ch2_event", event_valid, 1);
    chk("lit_ch2_event_code", event_code, 2);
    chk("lit_ch2_alarm", alarm_high, 4'b0100);
    step();

    ack = 1'b1; ack_ch = 2'd1; step(); ack = 1'b0;
    chk("lit_ack_ignored", alarm_low, 4'b0010);
    ack = 1'b1; ack_ch = 2'd2; step(); ack = 1'b0;
    chk("lit_ack2_ignored", alarm_high, 4'b0100);
    send(1, 7); step();
    ack = 1'b1; ack_ch = 2'd1; step(); ack = 1'b0;
    chk("lit_ack_clears", alarm_low, 0);

    send(1, 5); send(1, 5); send(1, 5); step(); step();
    chk("lit_ch1_realarm", alarm_low, 4'b0010);
    send(1, 7);
    ack = 1'b1; ack_ch = 2'd1; step(); ack = 1'b0;
    chk("lit_ack_same_cycle", alarm_low, 0);
    step();

    for (int k = 0; k < 3; k++) begin
      send(0, 3); send(3, 12);
    end
    chk("lit_il_ev0", event_valid, 1);
    chk("lit_il_ev0_ch", event_ch, 0);
    chk("lit_il_ev0_code", event_code, 1);
    step();
    chk("lit_il_ev3", event_valid, 1);
    chk("lit_il_ev3_ch", event_ch, 3);
    chk("lit_il_ev3_code", event_code, 2);
    chk("lit_il_low", alarm_low, 4'b0001);
    chk("lit_il_high", alarm_high, 4'b1100);
    step();

    send(2, 9); send(2, 4); send(2, 11); step();
`ifdef BLOOD_PH_STATS_EN
    chk("lit_stat_min", stat_min, 4);
    chk("lit_stat_max", stat_max, 11);
`else
    chk("lit_stat_min_off", stat_min, 0);
    chk("lit_stat_max_off", stat_max, 0);
`endif

    send(1, 3);
    in_valid = 1'b1; in_ch = 2'd1; in_ph = 4'd3; rst = 1'b1;
    step();
    chk("lit_mid_rst_low", alarm_low, 0);
    chk("lit_mid_rst_high", alarm_high, 0);
    chk("lit_mid_rst_event", event_valid, 0);
`ifdef BLOOD_PH_STATS_EN
    chk("lit_rst_stat_min", stat_min, 15);
`else
    chk("lit_rst_stat_min", stat_min, 0);
`endif
    chk("lit_rst_stat_max", stat_max, 0);
    rst = 1'b0; in_valid = 1'b0;
    step();
    send(1, 3); send(1, 3); step(); step();
    chk("lit_flushed", alarm_low, 0);
    send(1, 3); step(); step();
    chk("lit_after_rst_alarm", alarm_low, 4'b0010);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
